multi_debouncer: RTL and testbench

- N-channel push-button conditioner for the elevator controller's floor and cabin call buttons. Replaces the single-channel synchroniser/edge-detector.
- Each channel is synchronised, then filtered by a per-channel stability counter. A change is accepted only after the synchronised input has differed from the clean level for STABLE_CYCLES consecutive qualified samples.
- Outputs per channel: clean level, single-cycle rise pulse, single-cycle fall pulse.
- An optional sample-enable input lets a shared prescaler stretch the filter window.

---
 rtl/elevator_pkg.sv | 7 +
 rtl/debounce_channel.sv | 70 +++++++
 rtl/multi_debouncer.sv | 53 +++++
 tb/tb_multi_debouncer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator-controller constants used to size and tune the button front end.
package elevator_pkg;

   localparam int N_BUTTONS               = 4;
   localparam int DEBOUNCE_STABLE_DEFAULT = 8;

endpackage : elevator_pkg

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, stability counter, clean level and edge pulses.
module debounce_channel #(
   parameter int STABLE_CYCLES = 8,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic noisy_in,
   input  logic sample_en,
   output logic clean_level,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic rise_next
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      s1_d    = noisy_in;
      s2_d    = s1_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      // Any sample matching the clean level restarts the window, qualified or not.
      if (s2_q == level_q) begin
         cnt_d = '0;
      end else if (sample_en) begin
         if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
            cnt_d   = '0;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign clean_level = level_q;
   assign rise_pulse  = rise_q;
   assign fall_pulse  = fall_q;
   assign rise_next   = rise_d;

endmodule : debounce_channel

// File: rtl/multi_debouncer.sv
// N-channel call-button conditioner; any_rise is registered alongside the per-channel pulses.
module multi_debouncer
   import elevator_pkg::*;
#(
   parameter int N_CH          = N_BUTTONS,
   parameter int STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] noisy_in,
   input  logic            sample_en,
   output logic [N_CH-1:0] clean_level,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic            any_rise
);

   logic [N_CH-1:0] rise_next;
   logic            any_rise_q, any_rise_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .noisy_in    (noisy_in[i]),
         .sample_en   (sample_en),
         .clean_level (clean_level[i]),
         .rise_pulse  (rise_pulse[i]),
         .fall_pulse  (fall_pulse[i]),
         .rise_next   (rise_next[i])
      );
   end

   // OR the next-state pulses so any_rise lands in the same cycle as rise_pulse.
   always_comb begin
      any_rise_d = |rise_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         any_rise_q <= 1'b0;
      end else begin
         any_rise_q <= any_rise_d;
      end
   end

   assign any_rise = any_rise_q;

endmodule : multi_debouncer

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with N_CH=4, STABLE_CYCLES=4.
module tb_multi_debouncer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] noisy_in;
   logic       sample_en;
   logic [3:0] clean_level;
   logic [3:0] rise_pulse;
   logic [3:0] fall_pulse;
   logic       any_rise;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] noisy;
      logic       en;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       any;
   } vec_t;

   vec_t vecs[$];

   multi_debouncer #(
      .N_CH          (4),
      .STABLE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .noisy_in    (noisy_in),
      .sample_en   (sample_en),
      .clean_level (clean_level),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .any_rise    (any_rise)
   );

   always #5 clk = ~clk;

   task automatic add_vec(input int n, input logic [3:0] noisy, input logic [3:0] lvl,
                          input logic [3:0] rise, input logic [3:0] fall, input logic any);
      vec_t v;
      v.noisy = noisy; v.en = 1'b1; v.lvl = lvl; v.rise = rise; v.fall = fall; v.any = any;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic check_out(input string name, input logic [3:0] e_lvl, input logic [3:0] e_rise,
                            input logic [3:0] e_fall, input logic e_any);
      checks++;
      if (clean_level !== e_lvl || rise_pulse !== e_rise || fall_pulse !== e_fall || any_rise !== e_any) begin
         errors++;
         $display("FAIL %s t=%0t: level=%b rise=%b fall=%b any=%b, required level=%b rise=%b fall=%b any=%b",
                  name, $time, clean_level, rise_pulse, fall_pulse, any_rise, e_lvl, e_rise, e_fall, e_any);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      noisy_in  = 4'b0000;
      sample_en = 1'b1;
      repeat (2) tick();
      check_out("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;

      // Clean step on ch0
      add_vec(5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add_vec(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
      add_vec(2, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      // Release ch0
      add_vec(5, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      add_vec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0);
      add_vec(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // Glitch on ch1: three cycles high is one short of acceptance
      add_vec(3, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add_vec(6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      // Bounce on ch2, then settle high
      for (int k = 0; k < 12; k++)
         add_vec(1, ((k / 2) % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add_vec(5, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      add_vec(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1);
      add_vec(2, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      // Simultaneous rise on ch0 and ch3
      add_vec(5, 4'b1101, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      add_vec(1, 4'b1101, 4'b1101, 4'b1001, 4'b0000, 1'b1);
      add_vec(2, 4'b1101, 4'b1101, 4'b0000, 4'b0000, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         noisy_in  = vecs[i].noisy;
         sample_en = vecs[i].en;
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].any);
      end

      // Reset mid-count with ch1 held high
      noisy_in = 4'b1111;
      for (int e = 0; e < 3; e++) begin
         tick();
         check_out($sformatf("precount%0d", e), 4'b1101, 4'b0000, 4'b0000, 1'b0);
      end
      rst = 1'b1;
      #1;
      check_out("async_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      noisy_in = 4'b0010;
      tick();
      check_out("rst_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;
      for (int e = 0; e < 7; e++) begin
         tick();
         check_out($sformatf("post_rst%0d", e), (e >= 5) ? 4'b0010 : 4'b0000,
                   (e == 5) ? 4'b0010 : 4'b0000, 4'b0000, e == 5);
      end

      // Prescaled ch3: enable every third edge, low glitch seen on a non-enable edge
      for (int e = 0; e < 20; e++) begin
         sample_en = (e % 3 == 0);
         noisy_in  = (e == 6) ? 4'b0010 : 4'b1010;
         tick();
         check_out($sformatf("presc%0d", e), (e >= 18) ? 4'b1010 : 4'b0010,
                   (e == 18) ? 4'b1000 : 4'b0000, 4'b0000, e == 18);
      end
      sample_en = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_multi_debouncer
